// File: rtl/dmem_responder.sv
// dmem_responder: synthesizable stand-in for the CPU's 128x32 SRAM-style data
// memory. Active-low CEN/WEN/OEN CPU port, a valid/ready preload port, and a
// post-reset sweep that zeroes the whole array before accesses are accepted.
module dmem_responder #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 7,
  parameter int DEPTH          = 128,
  parameter int CLEAR_ON_RESET = 1
) (
  // Rising-edge clock; tie to ~clk when the CPU samples on the falling edge.
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic              OEN,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              drop,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // The sweep counter carries one extra bit so the final address is an
  // ordinary compare rather than a wrap condition.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CLR_INC  = (ADDR_W+1)'(1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     clr_cnt;
  logic [DATA_W-1:0]   q_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                cpu_rd;
  logic                cpu_wr;

  // Next state, handshake outputs and the single shared write port select.
  // CPU writes win over the loader; ld_ready already excludes CEN=0 edges.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt[ADDR_W-1:0];
    mem_wdata = '0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        ld_ready = CEN;
        cpu_wr   = !CEN && !WEN;
        cpu_rd   = !CEN && WEN;
        if (cpu_wr) begin
          mem_we    = 1'b1;
          mem_waddr = A;
          mem_wdata = D;
        end else if (ld_valid && CEN) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = ld_data;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset lands in the sweep unless clearing is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read register, sweep counter and the ignored-access flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      clr_cnt <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= busy && !CEN;
      if (busy) begin
        clr_cnt <= clr_cnt + CLR_INC;
      end
      if (cpu_wr) begin
        q_reg <= D;
      end else if (cpu_rd) begin
        q_reg <= mem[A];
      end
    end
  end

  // Storage array, deliberately not reset; writes are suppressed while rst_n is low.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign Q = OEN ? '0 : q_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a behavioural model.
module tb_dmem_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              CEN, WEN, OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;
  logic              busy, drop;
  logic              ld_valid, ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .OEN(OEN),
    .Q(Q), .busy(busy), .drop(drop), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain word array, a count of sweep cycles left and
  // the last value presented on the read register.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_busy_left = 0;
  logic [DATA_W-1:0] m_q = '0;
  logic              m_drop = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy_left = DEPTH;
      m_q         = '0;
      m_drop      = 1'b0;
    end else begin
      m_drop = 1'b0;
      if (m_busy_left > 0) begin
        m_drop = !CEN;
        m_busy_left--;
        if (m_busy_left == 0) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end else if (!CEN) begin
        if (!WEN) begin
          m_mem[A] = D;
          m_q      = D;
        end else begin
          m_q = m_mem[A];
        end
      end else if (ld_valid) begin
        m_mem[ld_addr] = ld_data;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("Q", Q, OEN ? '0 : m_q);
    check("busy", 32'(busy), 32'(m_busy_left > 0));
    check("ld_ready", 32'(ld_ready), 32'((m_busy_left == 0) && CEN));
    check("drop", 32'(drop), 32'(m_drop));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp,
                    input string name);
    CEN = 1'b0; WEN = 1'b1; A = addr;
    tick();
    CEN = 1'b1;
    check(name, Q, exp);
  endtask

  initial begin : main
    int n;
    int drops;
    logic xfer;
    rst_n = 1'b0; CEN = 1'b1; WEN = 1'b1; OEN = 1'b0; A = '0; D = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_Q", Q, 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);

    // 1: sweep length and first read
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    check("sweep_len", 32'(n), 32'd128);
    rd(7'd5, 32'd0, "rd5_after_clear");

    // 2: loader preload then CPU reads
    ld_valid = 1'b1; ld_addr = 7'd0; ld_data = 32'd15;
    #1 check("ld_ready_idle", 32'(ld_ready), 32'd1);
    tick();
    ld_addr = 7'd1; ld_data = 32'd20;
    tick();
    ld_valid = 1'b0;
    rd(7'd0, 32'd15, "rd0_loaded");
    rd(7'd1, 32'd20, "rd1_loaded");

    // 3: write-through and readback
    CEN = 1'b0; WEN = 1'b0; A = 7'd4; D = 32'd30;
    tick();
    CEN = 1'b1; WEN = 1'b1;
    check("wr4_through", Q, 32'd30);
    rd(7'd1, 32'd20, "rd1_again");
    rd(7'd4, 32'd30, "rd4");

    // 4: loader stalled behind CPU, completes on first free edge
    CEN = 1'b0; WEN = 1'b1; A = 7'd4;
    ld_valid = 1'b1; ld_addr = 7'd9; ld_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1 check("ld_stall", 32'(ld_ready), 32'd0);
      tick();
    end
    CEN = 1'b1;
    #1 check("ld_release", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    rd(7'd9, 32'hDEAD, "rd9_stalled_load");

    // 5: output enable masks Q only
    rd(7'd4, 32'd30, "rd4_pre_oen");
    OEN = 1'b1;
    #1 check("oen_high", Q, 32'd0);
    OEN = 1'b0;
    #1 check("oen_low", Q, 32'd30);

    // 6: reset mid-sweep with a dropped CPU write
    ld_valid = 1'b1; ld_addr = 7'd100; ld_data = 32'd7;
    tick();
    ld_valid = 1'b0;
    rd(7'd100, 32'd7, "rd100_loaded");
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (60) tick();
    rst_n = 1'b0;
    #1 check("midsweep_rst_busy", 32'(busy), 32'd1);
    tick();
    rst_n = 1'b1;
    n = 0; drops = 0;
    while (busy && n < 300) begin
      if (n == 5) begin CEN = 1'b0; WEN = 1'b0; A = 7'd3; D = 32'd99; end
      tick(); n++;
      if (n == 6) begin CEN = 1'b1; WEN = 1'b1; end
      if (drop) drops++;
    end
    check("sweep_len_restart", 32'(n), 32'd128);
    check("drop_pulses", 32'(drops), 32'd1);
    rd(7'd3, 32'd0, "rd3_dropped");
    rd(7'd100, 32'd0, "rd100_cleared");

    // Randomized phase with loader hold discipline and one mid-run reset.
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        rst_n = 1'b0; ld_valid = 1'b0; CEN = 1'b1;
        tick();
        rst_n = 1'b1;
      end
      CEN = ($urandom_range(0, 2) == 0);
      WEN = $urandom_range(0, 1) != 0;
      A   = ADDR_W'($urandom());
      D   = $urandom();
      OEN = ($urandom_range(0, 5) == 0);
      if (!ld_valid) begin
        ld_valid = $urandom_range(0, 1) != 0;
        ld_addr  = ADDR_W'($urandom());
        ld_data  = $urandom();
      end
      xfer = ld_valid && CEN && (m_busy_left == 0);
      tick();
      if (xfer) ld_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
